// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IDLE/ISSUE/WAIT, one transaction per 3 cycles.
// Define MEM_ARB_RR_EN for round-robin ties; default is fixed priority (p0).
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic              owner;
    logic              we_q;
    logic              sel1;
    logic              grant;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

`ifdef MEM_ARB_RR_EN
    logic              last;
`endif

    // Choose which port wins this cycle; grant only from IDLE outside reset
    always_comb begin
        sel1 = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (p0_req && p1_req)
            sel1 = ~last;
        else
            sel1 = p1_req;
`else
        sel1 = p1_req & ~p0_req;
`endif
        grant = (state == IDLE) && !rst && (p0_req || p1_req);
    end

    assign p0_gnt = grant & ~sel1;
    assign p1_gnt = grant & sel1;
    assign busy   = (state != IDLE);

    // Read data is forwarded straight from memory in the completing cycle
    assign p0_rdata = (state == WAIT && !we_q && !owner) ? mem_rdata : rdata0_q;
    assign p1_rdata = (state == WAIT && !we_q &&  owner) ? mem_rdata : rdata1_q;

    // Transaction FSM with registered memory strobes and done pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            we_q      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            p0_done   <= 1'b0;
            p1_done   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
`ifdef MEM_ARB_RR_EN
            last      <= 1'b1;
`endif
        end else begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            p0_done <= 1'b0;
            p1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state  <= ISSUE;
                        owner  <= sel1;
                        mem_en <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last   <= sel1;
`endif
                        if (sel1) begin
                            we_q      <= p1_we;
                            mem_we    <= p1_we;
                            mem_addr  <= p1_addr;
                            mem_wdata <= p1_wdata;
                        end else begin
                            we_q      <= p0_we;
                            mem_we    <= p0_we;
                            mem_addr  <= p0_addr;
                            mem_wdata <= p0_wdata;
                        end
                    end
                end
                ISSUE: begin
                    state   <= WAIT;
                    p0_done <= ~owner;
                    p1_done <= owner;
                end
                WAIT: begin
                    state <= IDLE;
                    if (!we_q) begin
                        if (owner)
                            rdata1_q <= mem_rdata;
                        else
                            rdata0_q <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a scoreboard of expected transactions.
// Arbitration expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p0_gnt, p0_done;
    logic [15:0] p0_addr;
    logic [7:0]  p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_gnt, p1_done;
    logic [15:0] p1_addr;
    logic [7:0]  p1_wdata, p1_rdata;
    logic        mem_en, mem_we, busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    int checks;
    int failures;

    typedef struct {
        bit          port;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    int          o_wait;
    bit          o_g0, o_g1, o_gx;
    bit          o_en1, o_we1, o_bz1, o_dn1;
    logic [15:0] o_a1;
    logic [7:0]  o_wd1;
    bit          o_d0, o_d1, o_bz2, o_en2;
    logic [7:0]  o_r0, o_r1;

    mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] memf(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h83;
    endfunction

    // Memory model: read data appears the cycle after mem_en, zero otherwise
    always @(posedge clk) begin
        if (rst)
            mem_rdata <= 8'h00;
        else
            mem_rdata <= (mem_en && !mem_we) ? memf(mem_addr) : 8'h00;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // Wait (bounded) for a grant, then sample the ISSUE and WAIT cycles
    task automatic observe(input bit drop, input bit late1);
        o_wait = 0;
        @(negedge clk);
        while (!(p0_gnt || p1_gnt) && o_wait < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            o_wait++;
        end
        o_g0 = p0_gnt;
        o_g1 = p1_gnt;
        @(posedge clk); #1;
        if (drop) begin
            if (o_g0) begin p0_req = 1'b0; p0_addr = ~p0_addr; end
            if (o_g1) begin p1_req = 1'b0; p1_addr = ~p1_addr; end
        end
        if (late1) p1_req = 1'b1;
        @(negedge clk);
        o_en1 = mem_en; o_we1 = mem_we; o_a1 = mem_addr; o_wd1 = mem_wdata;
        o_bz1 = busy; o_dn1 = p0_done | p1_done; o_gx = p0_gnt | p1_gnt;
        @(posedge clk); #1;
        @(negedge clk);
        o_d0 = p0_done; o_d1 = p1_done; o_r0 = p0_rdata; o_r1 = p1_rdata;
        o_bz2 = busy; o_en2 = mem_en;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0; p0_wdata = 8'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 16'h0; p1_wdata = 8'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (p0_gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt got=%b want=0", p0_gnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
        checks++; if ({mem_en, mem_we} !== 2'b00) begin failures++; $display("FAIL rst_mem got=%b want=00", {mem_en, mem_we}); end
        checks++; if ({mem_addr, mem_wdata} !== 24'h0) begin failures++; $display("FAIL rst_addr got=%h want=0", {mem_addr, mem_wdata}); end
        checks++; if ({p0_rdata, p1_rdata} !== 16'h0) begin failures++; $display("FAIL rst_rdata got=%h want=0", {p0_rdata, p1_rdata}); end
        checks++; if ({p0_done, p1_done} !== 2'b00) begin failures++; $display("FAIL rst_done got=%b want=00", {p0_done, p1_done}); end
        @(posedge clk); #1;
        rst = 1'b0;
        p0_req = 1'b0;
    endtask

    task automatic test_read_p0();
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h1234;
        sbq.push_back('{1'b0, 1'b0, 16'h1234, 8'h00, memf(16'h1234)});
        observe(1'b1, 1'b0);
        e = sbq.pop_front();
        checks++; if ({o_g1, o_g0} !== 2'b01) begin failures++; $display("FAIL rd_gnt got=%b want=01", {o_g1, o_g0}); end
        checks++; if (o_wait !== 0) begin failures++; $display("FAIL rd_gnt_delay got=%0d want=0", o_wait); end
        checks++; if ({o_en1, o_we1} !== 2'b10) begin failures++; $display("FAIL rd_mem got=%b want=10", {o_en1, o_we1}); end
        checks++; if (o_a1 !== e.addr) begin failures++; $display("FAIL rd_addr got=%h want=%h", o_a1, e.addr); end
        checks++; if ({o_bz1, o_dn1} !== 2'b10) begin failures++; $display("FAIL rd_issue got=%b want=10", {o_bz1, o_dn1}); end
        checks++; if ({o_d1, o_d0} !== 2'b01) begin failures++; $display("FAIL rd_done got=%b want=01", {o_d1, o_d0}); end
        checks++; if (o_r0 !== 8'hA5) begin failures++; $display("FAIL rd_data got=%h want=a5", o_r0); end
        checks++; if ({o_bz2, o_en2} !== 2'b10) begin failures++; $display("FAIL rd_wait got=%b want=10", {o_bz2, o_en2}); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (p0_rdata !== e.rdata) begin failures++; $display("FAIL rd_hold got=%h want=%h", p0_rdata, e.rdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_idle got=%b want=0", busy); end
    endtask

    task automatic test_write_p1();
        @(posedge clk); #1;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0F00;
        sbq.push_back('{1'b1, 1'b0, 16'h0F00, 8'h00, memf(16'h0F00)});
        observe(1'b1, 1'b0);
        e = sbq.pop_front();
        checks++; if ({o_d1, o_d0} !== 2'b10) begin failures++; $display("FAIL p1rd_done got=%b want=10", {o_d1, o_d0}); end
        checks++; if (o_r1 !== e.rdata) begin failures++; $display("FAIL p1rd_data got=%h want=%h", o_r1, e.rdata); end
        @(posedge clk); #1;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'hFFFF; p1_wdata = 8'h3C;
        sbq.push_back('{1'b1, 1'b1, 16'hFFFF, 8'h3C, e.rdata});
        observe(1'b1, 1'b0);
        e = sbq.pop_front();
        checks++; if ({o_g1, o_g0} !== 2'b10) begin failures++; $display("FAIL wr_gnt got=%b want=10", {o_g1, o_g0}); end
        checks++; if ({o_en1, o_we1} !== 2'b11) begin failures++; $display("FAIL wr_mem got=%b want=11", {o_en1, o_we1}); end
        checks++; if (o_a1 !== 16'hFFFF) begin failures++; $display("FAIL wr_addr got=%h want=ffff", o_a1); end
        checks++; if (o_wd1 !== 8'h3C) begin failures++; $display("FAIL wr_data got=%h want=3c", o_wd1); end
        checks++; if ({o_d1, o_d0} !== 2'b10) begin failures++; $display("FAIL wr_done got=%b want=10", {o_d1, o_d0}); end
        checks++; if (o_r1 !== e.rdata) begin failures++; $display("FAIL wr_p1rdata got=%h want=%h", o_r1, e.rdata); end
        checks++; if (o_r0 !== 8'hA5) begin failures++; $display("FAIL wr_p0rdata got=%h want=a5", o_r0); end
    endtask

    task automatic test_arbitration();
        bit pt;
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h00FF;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'hAB00;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            pt = (i % 2 == 1);
`else
            pt = 1'b0;
`endif
            if (pt)
                sbq.push_back('{1'b1, 1'b0, 16'hAB00, 8'h00, memf(16'hAB00)});
            else
                sbq.push_back('{1'b0, 1'b0, 16'h00FF, 8'h00, memf(16'h00FF)});
        end
        for (int i = 0; i < 4; i++) begin
            observe(1'b0, 1'b0);
            e = sbq.pop_front();
            checks++; if ({o_g1, o_g0} !== (e.port ? 2'b10 : 2'b01)) begin failures++; $display("FAIL arb_gnt%0d got=%b want_port=%0d", i, {o_g1, o_g0}, e.port); end
            checks++; if (o_wait !== 0) begin failures++; $display("FAIL arb_spacing%0d got=%0d want=0", i, o_wait); end
            checks++; if (o_a1 !== e.addr) begin failures++; $display("FAIL arb_addr%0d got=%h want=%h", i, o_a1, e.addr); end
            checks++; if ((e.port ? o_r1 : o_r0) !== e.rdata) begin failures++; $display("FAIL arb_rdata%0d got=%h want=%h", i, (e.port ? o_r1 : o_r0), e.rdata); end
            @(posedge clk); #1;
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic test_queued();
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h8001;
        p1_we = 1'b0; p1_addr = 16'h5A00;
        sbq.push_back('{1'b0, 1'b0, 16'h8001, 8'h00, memf(16'h8001)});
        sbq.push_back('{1'b1, 1'b0, 16'h5A00, 8'h00, memf(16'h5A00)});
        observe(1'b1, 1'b1);
        e = sbq.pop_front();
        checks++; if ({o_g1, o_g0} !== 2'b01) begin failures++; $display("FAIL q_gnt0 got=%b want=01", {o_g1, o_g0}); end
        checks++; if (o_gx !== 1'b0) begin failures++; $display("FAIL q_busy_gnt got=%b want=0", o_gx); end
        checks++; if (o_a1 !== e.addr) begin failures++; $display("FAIL q_addr0 got=%h want=%h", o_a1, e.addr); end
        checks++; if (o_r0 !== e.rdata) begin failures++; $display("FAIL q_rdata0 got=%h want=%h", o_r0, e.rdata); end
        @(posedge clk); #1;
        observe(1'b1, 1'b0);
        e = sbq.pop_front();
        checks++; if ({o_g1, o_g0} !== 2'b10) begin failures++; $display("FAIL q_gnt1 got=%b want=10", {o_g1, o_g0}); end
        checks++; if (o_wait !== 0) begin failures++; $display("FAIL q_delay got=%0d want=0", o_wait); end
        checks++; if (o_a1 !== e.addr) begin failures++; $display("FAIL q_addr1 got=%h want=%h", o_a1, e.addr); end
        checks++; if (o_r1 !== e.rdata) begin failures++; $display("FAIL q_rdata1 got=%h want=%h", o_r1, e.rdata); end
    endtask

    task automatic test_reset_abort();
        @(posedge clk); #1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h4321;
        @(negedge clk);
        checks++; if (p0_gnt !== 1'b1) begin failures++; $display("FAIL ab_gnt got=%b want=1", p0_gnt); end
        @(posedge clk); #1;
        p0_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL ab_issue got=%b want=1", mem_en); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({busy, p0_done, mem_en} !== 3'b000) begin failures++; $display("FAIL ab_state got=%b want=000", {busy, p0_done, mem_en}); end
        checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL ab_addr got=%h want=0", mem_addr); end
        checks++; if ({p0_rdata, p1_rdata} !== 16'h0) begin failures++; $display("FAIL ab_rdata got=%h want=0", {p0_rdata, p1_rdata}); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (p0_done !== 1'b0) begin failures++; $display("FAIL ab_late_done got=%b want=0", p0_done); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_read_p0();
        test_write_p1();
        test_arbitration();
        test_queued();
        test_reset_abort();
        checks++; if (sbq.size() !== 0) begin failures++; $display("FAIL sb_leftover got=%0d want=0", sbq.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
